// File: rtl/fetch_unit.sv
// 6502 instruction fetch stage: loads the reset vector, then fetches
// opcode plus operand bytes and hands complete instructions to the decoder.
module fetch_unit #(
    parameter int REG_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic                  get_next,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic [REG_WIDTH-1:0]  instruction,
    output logic [ADDR_WIDTH-1:0] operand,
    output logic [1:0]            inst_len,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  instruction_ready,
    output logic [ADDR_WIDTH-1:0] pc
);

    typedef enum logic [3:0] {
        RST, VEC_LO, VEC_HI, VEC_CAP, FETCH,
        DECODE, OPLO, OPHI, READY, WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [REG_WIDTH-1:0]  lo_q, lo_d;
    logic [REG_WIDTH-1:0]  inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] op_q, op_d;
    logic [1:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            dec_len;

    // Length from opcode pattern aaabbbcc
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [2:0] bbb;
        logic [1:0] cc;
        bbb = op[4:2];
        cc  = op[1:0];
        op_len = 2'd1;
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) begin
            op_len = 2'd1;
        end else if (op == 8'h20) begin
            op_len = 2'd3;
        end else if (cc == 2'b11) begin
            op_len = 2'd1;
        end else if (cc == 2'b01) begin
            if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111)
                op_len = 2'd3;
            else
                op_len = 2'd2;
        end else begin
            case (bbb)
                3'b011, 3'b111:         op_len = 2'd3;
                3'b010, 3'b110:         op_len = 2'd1;
                3'b000, 3'b001, 3'b101: op_len = 2'd2;
                default:                op_len = (cc == 2'b00) ? 2'd2 : 2'd1;
            endcase
        end
    endfunction

    assign dec_len = op_len(mem_rdata[7:0]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RST;
            pc_q    <= '0;
            lo_q    <= '0;
            inst_q  <= '0;
            op_q    <= '0;
            len_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lo_q    <= lo_d;
            inst_q  <= inst_d;
            op_q    <= op_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        lo_d     = lo_q;
        inst_d   = inst_q;
        op_d     = op_q;
        len_d    = len_q;
        addr_d   = addr_q;
        mem_rd   = 1'b0;
        mem_addr = '0;
        instruction_ready = 1'b0;
        case (state_q)
            RST: state_d = VEC_LO;
            VEC_LO: begin
                mem_rd   = 1'b1;
                mem_addr = RESET_VECTOR;
                state_d  = VEC_HI;
            end
            VEC_HI: begin
                lo_d     = mem_rdata;
                mem_rd   = 1'b1;
                mem_addr = RESET_VECTOR + 1'b1;
                state_d  = VEC_CAP;
            end
            VEC_CAP: begin
                pc_d    = {mem_rdata, lo_q};
                state_d = FETCH;
            end
            FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q;
                addr_d   = pc_q;
                pc_d     = pc_q + 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                inst_d = mem_rdata;
                op_d   = '0;
                len_d  = dec_len;
                if (dec_len == 2'd1) begin
                    state_d = READY;
                end else begin
                    mem_rd   = 1'b1;
                    mem_addr = pc_q;
                    pc_d     = pc_q + 1'b1;
                    state_d  = OPLO;
                end
            end
            OPLO: begin
                op_d[7:0] = mem_rdata;
                if (len_q == 2'd3) begin
                    mem_rd   = 1'b1;
                    mem_addr = pc_q;
                    pc_d     = pc_q + 1'b1;
                    state_d  = OPHI;
                end else begin
                    state_d = READY;
                end
            end
            OPHI: begin
                op_d[15:8] = mem_rdata;
                state_d    = READY;
            end
            READY: begin
                instruction_ready = 1'b1;
                state_d = get_next ? FETCH : WAIT;
            end
            WAIT: if (get_next) state_d = FETCH;
            default: state_d = RST;
        endcase
        // A reload discards whatever this cycle would have captured
        if (pc_load && state_q inside {FETCH, DECODE, OPLO, OPHI, READY, WAIT}) begin
            pc_d    = pc_load_value;
            state_d = FETCH;
            inst_d  = inst_q;
            op_d    = op_q;
            len_d   = len_q;
            addr_d  = addr_q;
        end
    end

    assign pc          = pc_q;
    assign instruction = inst_q;
    assign operand     = op_q;
    assign inst_len    = len_q;
    assign address_out = addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        get_next;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic [7:0]  instruction;
    logic [15:0] operand;
    logic [1:0]  inst_len;
    logic [15:0] address_out;
    logic        instruction_ready;
    logic [15:0] pc;

    logic [7:0] mem [0:65535];
    int tests = 0;
    int fails = 0;
    int lat;

    fetch_unit dut (
        .clk(clk),
        .reset_n(reset_n),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_rdata(mem_rdata),
        .get_next(get_next),
        .pc_load(pc_load),
        .pc_load_value(pc_load_value),
        .instruction(instruction),
        .operand(operand),
        .inst_len(inst_len),
        .address_out(address_out),
        .instruction_ready(instruction_ready),
        .pc(pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (instruction_ready !== 1'b1 && n < 20);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, pc, 16'h0000);
        chk({tag, "_ins"}, instruction, 8'h00);
        chk({tag, "_opd"}, operand, 16'h0000);
        chk({tag, "_len"}, inst_len, 2'd0);
        chk({tag, "_adr"}, address_out, 16'h0000);
        chk({tag, "_rdy"}, instruction_ready, 1'b0);
        chk({tag, "_rd"}, mem_rd, 1'b0);
        chk({tag, "_ma"}, mem_addr, 16'h0000);
    endtask

    task automatic pulse_next;
        get_next = 1'b1;
        @(negedge clk);
        get_next = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
        mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h34;
        mem[16'h8004] = 8'h12;
        mem[16'h8005] = 8'hEA; mem[16'h8006] = 8'h00;
        mem[16'h8007] = 8'h20; mem[16'h8008] = 8'h00;
        mem[16'h8009] = 8'h90;
        mem[16'hC000] = 8'hA2; mem[16'hC001] = 8'h07;
        mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h05;
        mem[16'h0001] = 8'h8D; mem[16'h0002] = 8'h78;
        mem[16'h0003] = 8'h56;

        reset_n = 1'b0; get_next = 1'b0;
        pc_load = 1'b0; pc_load_value = 16'h0000;
        repeat (3) @(negedge clk);
        chk_reset("rst");

        reset_n = 1'b1;
        @(negedge clk);
        chk("vlo_rd", mem_rd, 1'b1);
        chk("vlo_ma", mem_addr, 16'hFFFC);
        @(negedge clk);
        chk("vhi_ma", mem_addr, 16'hFFFD);
        @(negedge clk);
        chk("vcap_rd", mem_rd, 1'b0);
        @(negedge clk);
        chk("f0_ma", mem_addr, 16'h8000);
        chk("f0_pc", pc, 16'h8000);
        chk("f0_rdy", instruction_ready, 1'b0);

        wait_ready(lat);
        chk("lda_lat", lat, 3);
        chk("lda_ins", instruction, 8'hA9);
        chk("lda_opd", operand, 16'h0042);
        chk("lda_len", inst_len, 2'd2);
        chk("lda_adr", address_out, 16'h8000);
        chk("lda_pc", pc, 16'h8002);

        pulse_next;
        chk("sta_ma", mem_addr, 16'h8002);
        wait_ready(lat);
        chk("sta_lat", lat, 4);
        chk("sta_ins", instruction, 8'h8D);
        chk("sta_opd", operand, 16'h1234);
        chk("sta_len", inst_len, 2'd3);
        chk("sta_adr", address_out, 16'h8002);
        chk("sta_pc", pc, 16'h8005);

        pulse_next;
        wait_ready(lat);
        chk("nop_lat", lat, 2);
        chk("nop_ins", instruction, 8'hEA);
        chk("nop_opd", operand, 16'h0000);
        chk("nop_len", inst_len, 2'd1);
        chk("nop_adr", address_out, 16'h8005);

        pulse_next;
        wait_ready(lat);
        chk("brk_lat", lat, 2);
        chk("brk_ins", instruction, 8'h00);
        chk("brk_len", inst_len, 2'd1);
        chk("brk_adr", address_out, 16'h8006);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("wait_rd", mem_rd, 1'b0);
            chk("wait_rdy", instruction_ready, 1'b0);
        end
        chk("wait_ins", instruction, 8'h00);
        chk("wait_adr", address_out, 16'h8006);
        chk("wait_pc", pc, 16'h8007);

        pulse_next;
        chk("jsr_ma", mem_addr, 16'h8007);
        @(negedge clk);
        @(negedge clk);
        chk("oplo_ma", mem_addr, 16'h8009);
        pc_load = 1'b1; pc_load_value = 16'hC000;
        @(negedge clk);
        pc_load = 1'b0;
        chk("ld_rdy", instruction_ready, 1'b0);
        chk("ld_ma", mem_addr, 16'hC000);
        wait_ready(lat);
        chk("ldx_lat", lat, 3);
        chk("ldx_ins", instruction, 8'hA2);
        chk("ldx_opd", operand, 16'h0007);
        chk("ldx_adr", address_out, 16'hC000);

        @(negedge clk);
        pc_load = 1'b1; pc_load_value = 16'hFFFF;
        @(negedge clk);
        pc_load = 1'b0;
        chk("wr_ma", mem_addr, 16'hFFFF);
        wait_ready(lat);
        chk("wr_lat", lat, 3);
        chk("wr_ins", instruction, 8'hA9);
        chk("wr_opd", operand, 16'h0005);
        chk("wr_adr", address_out, 16'hFFFF);
        chk("wr_pc", pc, 16'h0001);

        pulse_next;
        chk("abs_ma", mem_addr, 16'h0001);
        repeat (3) @(negedge clk);
        chk("ophi_rd", mem_rd, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset("rst2");
        reset_n = 1'b1;
        @(negedge clk);
        chk("rv_ma", mem_addr, 16'hFFFC);
        chk("rv_rd", mem_rd, 1'b1);
        repeat (3) @(negedge clk);
        chk("rf_ma", mem_addr, 16'h8000);
        wait_ready(lat);
        chk("rf_lat", lat, 3);
        chk("rf_opd", operand, 16'h0042);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
